// File: rtl/load_use_stall.sv
// ---------------------------------------------------------------------------
// load_use_stall
//
// Load-use hazard interlock for the five-stage LEGv8 pipeline, placed between
// IF/ID and ID/EX. It decodes the source registers of the instruction in
// decode and compares them with the destination of an LDUR sitting in
// execute. On a hit it holds PC and IF/ID and feeds NOP bubbles into ID/EX
// for STALL_CYCLES cycles, after which the held instruction is released.
// A saturating counter records the total number of stall cycles.
//
// Parameters
//   STALL_CYCLES  bubbles per load-use hit, 1..3 (1 with MEM-to-EX
//                 forwarding, 2 without)
//   CNT_W         width of the stall-cycle counter
//
// Ports
//   clk         in   pipeline clock
//   reset       in   synchronous active-high reset
//   instrID     in   instruction currently in IF/ID
//   validID     in   instrID is a real instruction (not a bubble/flush)
//   exMemRead   in   instruction in ID/EX is an LDUR
//   exRd        in   destination register of the instruction in ID/EX
//   stall       out  write-disable for PC and IF/ID
//   instrOut    out  instruction forwarded to ID/EX (instrID or NOP)
//   stallCount  out  stall cycles since reset, saturating at all-ones
//
// FSM states
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no episode in progress; stall follows the combinational hit
//   S_STALL | extra bubble cycles of an episode (STALL_CYCLES > 1 only);
//           | remain counts down to 1, then control returns to S_IDLE
// ---------------------------------------------------------------------------
module load_use_stall #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrID,
  input  logic             validID,
  input  logic             exMemRead,
  input  logic [4:0]       exRd,
  output logic             stall,
  output logic [31:0]      instrOut,
  output logic [CNT_W-1:0] stallCount
);

  // ADDI X31, X31, #0
  localparam logic [31:0] NOP_INSTR = 32'h910003FF;

  // First cycle of an episode is the hit cycle itself; the rest are counted
  // down in S_STALL.
  localparam logic [1:0]  REMAIN_INIT = 2'(STALL_CYCLES - 1);

  localparam logic [4:0]  XZR = 5'd31;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t             state_q,       state_d;
  logic [1:0]         remain_q,      remain_d;
  logic [4:0]         held_rd_q,     held_rd_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  // -------------------------------------------------------------------------
  // Source register decode
  // -------------------------------------------------------------------------
  logic [10:0] opcode;
  logic [4:0]  src_rn;
  logic [4:0]  src_rm;
  logic [4:0]  src_rt;
  logic        use_rn;
  logic        use_rm;
  logic        use_rt;
  logic        rd_match;
  logic        hit;

  assign opcode = instrID[31:21];
  assign src_rn = instrID[9:5];
  assign src_rm = instrID[20:16];
  assign src_rt = instrID[4:0];

  always_comb begin
    use_rn = 1'b0;
    use_rm = 1'b0;
    use_rt = 1'b0;
    casez (opcode)
      11'b10001011000,                   // ADD
      11'b11001011000,                   // SUB
      11'b10001010000,                   // AND
      11'b10101010000: begin             // ORR
        use_rn = 1'b1;
        use_rm = 1'b1;
      end
      11'b1001000100?,                   // ADDI
      11'b11111000010: begin             // LDUR
        use_rn = 1'b1;
      end
      11'b11111000000: begin             // STUR: Rt is the store data source
        use_rn = 1'b1;
        use_rt = 1'b1;
      end
      11'b10110100???: begin             // CBZ
        use_rt = 1'b1;
      end
      default: begin                     // B and everything else
        use_rn = 1'b0;
      end
    endcase
  end

  assign rd_match = (use_rn && (src_rn == exRd)) ||
                    (use_rm && (src_rm == exRd)) ||
                    (use_rt && (src_rt == exRd));

  // XZR is never really written, so a load into X31 is not a hazard.
  // Decode is gated by reset so the pipeline sees no stall while resetting.
  assign hit = !reset && validID && exMemRead && (exRd != XZR) && rd_match;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      remain_q      <= 2'd0;
      held_rd_q     <= 5'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      held_rd_q     <= held_rd_d;
      stall_count_q <= stall_count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    held_rd_d = held_rd_q;
    case (state_q)
      S_IDLE: begin
        // With a single bubble the episode fits entirely in the hit cycle;
        // the bubble then sits in EX so exMemRead drops on its own.
        if (hit && (STALL_CYCLES > 1)) begin
          state_d   = S_STALL;
          remain_d  = REMAIN_INIT;
          held_rd_d = exRd;
        end
      end
      S_STALL: begin
        remain_d = remain_q - 2'd1;
        // <= 1 rather than == 1 so a corrupted zero cannot lock the pipe.
        if (remain_q <= 2'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE:  stall = hit;
        S_STALL: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
    instrOut = stall ? NOP_INSTR : instrID;
  end

  // -------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // -------------------------------------------------------------------------
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  assign stallCount = stall_count_q;

endmodule

// File: tb/tb_load_use_stall.sv
// ---------------------------------------------------------------------------
// tb_load_use_stall
//
// Four instances share one input stream: STALL_CYCLES 1/2/3 with a 16-bit
// counter, plus STALL_CYCLES 1 with a 2-bit counter for saturation. Each is
// compared every cycle against a bubble-budget reference model, first with
// directed scenarios and then with random instruction traffic.
// ---------------------------------------------------------------------------
module tb_load_use_stall;

  localparam logic [31:0] NOP = 32'h910003FF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        valid;
  logic        memrd;
  logic [4:0]  rd;

  logic        st [4];
  logic [31:0] io [4];
  logic [15:0] cnt16 [3];
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  // Model state: bubbles still owed after the current cycle, and counts.
  int          bub  [4];
  longint      cnt  [4];
  int          sc   [4] = '{1, 2, 3, 1};
  longint      cmax [4] = '{65535, 65535, 65535, 3};

  always #5 clk = ~clk;

  load_use_stall #(.STALL_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .instrID(instr), .validID(valid),
    .exMemRead(memrd), .exRd(rd), .stall(st[0]), .instrOut(io[0]),
    .stallCount(cnt16[0]));
  load_use_stall #(.STALL_CYCLES(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .instrID(instr), .validID(valid),
    .exMemRead(memrd), .exRd(rd), .stall(st[1]), .instrOut(io[1]),
    .stallCount(cnt16[1]));
  load_use_stall #(.STALL_CYCLES(3), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .instrID(instr), .validID(valid),
    .exMemRead(memrd), .exRd(rd), .stall(st[2]), .instrOut(io[2]),
    .stallCount(cnt16[2]));
  load_use_stall #(.STALL_CYCLES(1), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset), .instrID(instr), .validID(valid),
    .exMemRead(memrd), .exRd(rd), .stall(st[3]), .instrOut(io[3]),
    .stallCount(cnt2));

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_cnt(input int i);
    if (i == 3) return {30'd0, cnt2};
    return {16'd0, cnt16[i]};
  endfunction

  // Does the instruction read register r, per the LEGv8 source table?
  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [10:0] op;
    op = ins[31:21];
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000)
      return (ins[9:5] == r) || (ins[20:16] == r);
    if (ins[31:22] == 10'b1001000100 || op == 11'b11111000010)
      return ins[9:5] == r;
    if (op == 11'b11111000000)
      return (ins[9:5] == r) || (ins[4:0] == r);
    if (ins[31:24] == 8'b10110100)
      return ins[4:0] == r;
    return 1'b0;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then let the edge happen. Inputs must already be applied.
  task automatic step();
    bit hit;
    bit exp_st;
    @(negedge clk);
    hit = !reset && valid && memrd && (rd != 5'd31) && reads_reg(instr, rd);
    for (int i = 0; i < 4; i++) begin
      exp_st = !reset && ((bub[i] > 0) || hit);
      check_eq($sformatf("stall[%0d]", i), {31'd0, st[i]}, {31'd0, exp_st});
      check_eq($sformatf("instrOut[%0d]", i), io[i], exp_st ? NOP : instr);
      check_eq($sformatf("stallCount[%0d]", i), obs_cnt(i), 32'(cnt[i]));
      if (reset) begin
        bub[i] = 0;
        cnt[i] = 0;
      end else begin
        if (bub[i] > 0) bub[i]--;
        else if (hit) bub[i] = sc[i] - 1;
        if (exp_st && cnt[i] < cmax[i]) cnt[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 8);
    return (k == 8) ? 5'd31 : 5'(k);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = pick_reg(); b = pick_reg(); c = pick_reg();
    case ($urandom_range(0, 9))
      0: return {11'b10001011000, b, 6'd0, a, c};
      1: return {11'b11001011000, b, 6'd0, a, c};
      2: return {11'b10001010000, b, 6'd0, a, c};
      3: return {11'b10101010000, b, 6'd0, a, c};
      4: return {10'b1001000100, 12'($urandom), a, c};
      5: return {11'b11111000010, 9'($urandom), 2'b00, a, c};
      6: return {11'b11111000000, 9'($urandom), 2'b00, a, c};
      7: return {8'b10110100, 19'($urandom), c};
      8: return {6'b000101, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] ADD_1_2_3   = {11'b10001011000, 5'd3, 6'd0, 5'd2, 5'd1};
  localparam logic [31:0] ADD_1_31_31 = {11'b10001011000, 5'd31, 6'd0, 5'd31, 5'd1};
  localparam logic [31:0] STUR_7_9    = {11'b11111000000, 9'd0, 2'b00, 5'd9, 5'd7};
  localparam logic [31:0] B_4         = {6'b000101, 26'd1};
  localparam logic [31:0] ADD_4_4_4   = {11'b10001011000, 5'd4, 6'd0, 5'd4, 5'd4};

  initial begin
    for (int i = 0; i < 4; i++) begin
      bub[i] = 0;
      cnt[i] = 0;
    end
    reset = 1'b1; instr = ADD_1_2_3; valid = 1'b1; memrd = 1'b1; rd = 5'd2;
    #1;
    step(); step();

    // No hazard
    reset = 1'b0; rd = 5'd5;
    step(); step();
    check_eq("no_hazard_cnt", obs_cnt(0), 32'd0);

    // Single hit, then the bubble occupies EX
    rd = 5'd2;
    step();
    memrd = 1'b0;
    step(); step(); step();
    check_eq("hit_cnt_sc1", obs_cnt(0), 32'd1);
    check_eq("hit_cnt_sc2", obs_cnt(1), 32'd2);
    check_eq("hit_cnt_sc3", obs_cnt(2), 32'd3);

    // STUR data-register hit
    reset = 1'b1; step(); reset = 1'b0;
    instr = STUR_7_9; memrd = 1'b1; rd = 5'd7;
    step();
    memrd = 1'b0;
    step(); step(); step();
    check_eq("stur_cnt_sc2", obs_cnt(1), 32'd2);

    // XZR, branch, invalid slot
    memrd = 1'b1; instr = ADD_1_31_31; rd = 5'd31; step();
    instr = B_4; rd = 5'd3; step();
    instr = ADD_4_4_4; rd = 5'd4; valid = 1'b0; step();
    valid = 1'b1;
    check_eq("no_stall_cnt", obs_cnt(0), 32'd1);

    // Reset on the second stall cycle of a 3-bubble episode
    reset = 1'b1; step(); reset = 1'b0;
    instr = ADD_1_2_3; rd = 5'd2; memrd = 1'b1;
    step();
    memrd = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_eq("rst_mid_stall", {31'd0, st[2]}, 32'd0);
    check_eq("rst_mid_cnt", obs_cnt(2), 32'd0);

    // Saturation of the 2-bit counter: 1,2,3,3,3
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      memrd = 1'b1; rd = 5'd2; instr = ADD_1_2_3;
      step();
      check_eq($sformatf("sat_%0d", k), obs_cnt(3), (k > 3) ? 32'd3 : 32'(k));
      memrd = 1'b0;
      step(); step(); step();
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      instr = rand_instr();
      valid = ($urandom_range(0, 99) < 85);
      memrd = $urandom_range(0, 1);
      rd    = pick_reg();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
